vd_frame_ctrl: RTL and testbench
================================

VD_FRAME_CTRL -- requirements
Module: vd_frame_ctrl

Interface
REQ-001 Parameter FRAME_W, 16, width of frame_len and the internal symbol counters.
REQ-002 Parameter TAIL_LEN, 8, number of zero tail symbols flushed after each frame (constraint length 9, so K-1).
REQ-003 Parameter DEC_LATENCY, 64, CLOCK cycles from a symbol on dec_code to its decoded bit on dec_out; legal range is 1 or more.
REQ-004 Port CLOCK  in  1  single clock; every register is clocked on the rising edge.
REQ-005 Port Reset  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  one-cycle frame start request.
REQ-007 Port frame_len  in  FRAME_W  number of information symbols in the frame; sampled when start is accepted.
REQ-008 Port in_valid  in  1  upstream code symbol valid.
REQ-009 Port in_code  in  WD_CODE  upstream code symbol.
REQ-010 Port in_ready  out  1  controller accepts in_code this cycle.
REQ-011 Port dec_active  out  1  drives the decoder Active input.
REQ-012 Port dec_code  out  WD_CODE  drives the decoder Code input.
REQ-013 Port dec_out  in  1  decoder DecodeOut.
REQ-014 Port out_valid  out  1  out_bit is a decoded information bit.
REQ-015 Port out_bit  out  1  registered copy of dec_out.
REQ-016 Port busy  out  1  high whenever the state is not IDLE.
REQ-017 Port done  out  1  one-cycle pulse at the end of a frame.
REQ-018 Port err_underrun  out  1  sticky flag: a RUN cycle had no valid symbol; cleared by the next accepted start.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, RUN, FLUSH, DRAIN and DONE.
REQ-020 IDLE: start=1 with frame_len>0 -> RUN; start=1 with frame_len=0 -> DONE, and dec_active stays low.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 RUN: in_ready=1; exactly one symbol SHALL be presented on dec_code per cycle, registered, so dec_code changes one cycle after acceptance.
REQ-023 RUN with in_valid=0: dec_code SHALL be 0, err_underrun SHALL be set, and the underrun symbol SHALL count toward frame_len.
REQ-024 RUN SHALL exit after frame_len presented symbols, to FLUSH when the flush feature is compiled in and to DRAIN otherwise.
REQ-025 FLUSH: in_ready=0 and dec_code=0 for exactly TAIL_LEN cycles, then -> DRAIN.
REQ-026 DRAIN: in_ready=0 and dec_code=0 for DEC_LATENCY cycles after the last symbol is presented, then -> DONE.
REQ-027 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-028 dec_active SHALL rise with the first presented symbol and fall on entry to DONE.
REQ-029 out_valid SHALL assert exactly DEC_LATENCY+1 cycles after information symbol k is presented, for k=0..frame_len-1: frame_len cycles total, contiguous.
REQ-030 out_valid SHALL never assert for tail symbols.
REQ-031 out_bit SHALL hold its last value while out_valid=0.
REQ-032 Symbol counters SHALL be FRAME_W bits wide, compare for equality, and never wrap within a frame; frame_len = 2^FRAME_W-1 SHALL be legal.

Reset
REQ-033 Reset low SHALL immediately force state IDLE and drive in_ready, dec_active, dec_code, out_valid, out_bit, busy, done and err_underrun to 0.
REQ-034 Reset asserted mid-frame SHALL discard the frame, and no out_valid or done SHALL follow after Reset releases.
REQ-035 The controller SHALL leave IDLE only on a start sampled at or after the first rising edge following Reset release.

Configuration
REQ-036 Macro VD_FLUSH_EN defined: FLUSH state present and TAIL_LEN zero symbols inserted; undefined: FLUSH removed, RUN -> DRAIN directly, and TAIL_LEN unused.

Structure
REQ-037 WD_CODE SHALL come from the shared params.v macro; the state encoding SHALL be defined as shared constants in params.v.
REQ-038 The valid-alignment delay line (DEC_LATENCY+1 stages, 1 bit wide) SHALL be a sub-module named vd_valid_delay.

Verification
REQ-039 Reset low for 3 cycles, then high, with no start -> all outputs 0 and busy=0.
REQ-040 VD_FLUSH_EN defined, frame_len=16, in_valid held high -> in_ready high 16 cycles, FLUSH 8 cycles, out_valid high 16 cycles starting 65 cycles after the first dec_code, done once, err_underrun=0.
REQ-041 frame_len=4 with in_valid low on symbol 2 -> dec_code=0 that cycle, err_underrun=1, still exactly 4 out_valid cycles.
REQ-042 start with frame_len=0 -> done pulse on the next cycle, dec_active never high.
REQ-043 Reset pulsed low during DRAIN -> outputs 0 immediately, no out_valid or done afterwards; a new start then runs normally.
REQ-044 VD_FLUSH_EN undefined, frame_len=16 -> no FLUSH cycles, busy lasts 16+64+1 cycles plus the DONE cycle.

Source files
------------

// File: rtl/vd_frame_ctrl_pkg.sv
// Shared constants for the Viterbi-decoder frame controller: code symbol width,
// FSM state encoding and counter sizing helper.
package vd_frame_ctrl_pkg;

  localparam int unsigned WD_CODE = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bits needed to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vd_valid_delay.sv
// Valid-alignment shift register; pre is the stage just before q, so a
// consumer can load data on the same edge that q rises.
module vd_valid_delay #(
  parameter int unsigned DEPTH = 65
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pre,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign pre = sr[DEPTH-2];
  assign q   = sr[DEPTH-1];

endmodule

// File: rtl/vd_frame_ctrl.sv
// Frame controller feeding a Viterbi decoder: presents one symbol per cycle,
// optionally flushes TAIL_LEN zero symbols (macro VD_FLUSH_EN), drains the
// decoder pipeline and aligns out_valid with the decoded information bits.
module vd_frame_ctrl
  import vd_frame_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned TAIL_LEN    = 8,
  parameter int unsigned DEC_LATENCY = 64
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               in_valid,
  input  logic [WD_CODE-1:0] in_code,
  output logic               in_ready,
  output logic               dec_active,
  output logic [WD_CODE-1:0] dec_code,
  input  logic               dec_out,
  output logic               out_valid,
  output logic               out_bit,
  output logic               busy,
  output logic               done,
  output logic               err_underrun
);

  localparam int unsigned CNT_MAX = (DEC_LATENCY > TAIL_LEN) ? DEC_LATENCY : TAIL_LEN;
  localparam int unsigned CW      = cnt_width(CNT_MAX);
  // Drain spans the presentation cycle of the last symbol plus DEC_LATENCY.
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DEC_LATENCY);
`ifdef VD_FLUSH_EN
  localparam logic [CW-1:0] TAIL_LAST  = CW'(TAIL_LEN - 1);
`endif

  state_t             state;
  logic [FRAME_W-1:0] len_q;
  logic [FRAME_W-1:0] sym_cnt;
  logic [CW-1:0]      ph_cnt;
  logic               info_pres;
  logic               bit_load;

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      sym_cnt      <= '0;
      ph_cnt       <= '0;
      info_pres    <= 1'b0;
      in_ready     <= 1'b0;
      dec_active   <= 1'b0;
      dec_code     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      done      <= 1'b0;
      info_pres <= 1'b0;
      dec_code  <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_underrun <= 1'b0;
            len_q        <= frame_len;
            sym_cnt      <= '0;
            busy         <= 1'b1;
            if (frame_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_RUN;
              in_ready <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Underrun cycles still consume a slot in the frame as a zero symbol.
          dec_code   <= in_valid ? in_code : '0;
          dec_active <= 1'b1;
          info_pres  <= 1'b1;
          if (!in_valid) err_underrun <= 1'b1;
          sym_cnt <= sym_cnt + FRAME_W'(1);
          if (sym_cnt == len_q - FRAME_W'(1)) begin
            in_ready <= 1'b0;
            ph_cnt   <= '0;
`ifdef VD_FLUSH_EN
            state    <= ST_FLUSH;
`else
            state    <= ST_DRAIN;
`endif
          end
        end
`ifdef VD_FLUSH_EN
        ST_FLUSH: begin
          ph_cnt <= ph_cnt + CW'(1);
          if (ph_cnt == TAIL_LAST) begin
            ph_cnt <= '0;
            state  <= ST_DRAIN;
          end
        end
`endif
        ST_DRAIN: begin
          ph_cnt <= ph_cnt + CW'(1);
          if (ph_cnt == DRAIN_LAST) begin
            state      <= ST_DONE;
            dec_active <= 1'b0;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          in_ready   <= 1'b0;
          dec_active <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  vd_valid_delay #(
    .DEPTH(DEC_LATENCY + 1)
  ) u_valid_delay (
    .clk  (CLOCK),
    .rst_n(Reset),
    .d    (info_pres),
    .pre  (bit_load),
    .q    (out_valid)
  );

  // Capture the decoder bit on the edge where out_valid rises for it.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      out_bit <= 1'b0;
    end else if (bit_load) begin
      out_bit <= dec_out;
    end
  end

endmodule

// File: tb/tb_vd_frame_ctrl.sv
// Self-checking bench for vd_frame_ctrl against a cycle-timeline model derived
// from frame length, tail length and decoder latency; honours VD_FLUSH_EN.
module tb_vd_frame_ctrl;
  import vd_frame_ctrl_pkg::*;

  localparam int FW  = 8;
  localparam int TL  = 8;
  localparam int LAT = 64;
`ifdef VD_FLUSH_EN
  localparam int TAIL_EFF = TL;
`else
  localparam int TAIL_EFF = 0;
`endif

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [FW-1:0]      frame_len;
  logic               in_valid;
  logic [WD_CODE-1:0] in_code;
  logic               in_ready;
  logic               dec_active;
  logic [WD_CODE-1:0] dec_code;
  logic               dec_out;
  logic               out_valid;
  logic               out_bit;
  logic               busy;
  logic               done;
  logic               err_underrun;

  int   n_tests;
  int   n_fail;
  logic last_bit;

  vd_frame_ctrl #(
    .FRAME_W    (FW),
    .TAIL_LEN   (TL),
    .DEC_LATENCY(LAT)
  ) dut (
    .CLOCK       (clk),
    .Reset       (rst_n),
    .start       (start),
    .frame_len   (frame_len),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .in_ready    (in_ready),
    .dec_active  (dec_active),
    .dec_code    (dec_code),
    .dec_out     (dec_out),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .busy        (busy),
    .done        (done),
    .err_underrun(err_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder stand-in: output is the parity of the symbol seen LAT cycles earlier.
  logic [WD_CODE-1:0] hist [LAT];
  initial for (int i = 0; i < LAT; i++) hist[i] = '0;
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= dec_code;
  end
  assign dec_out = ^hist[LAT-1];

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; frame_len = FW'(5); in_valid = 1'b1; in_code = '1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready, dec_active, dec_code, out_valid, out_bit, busy, done, err_underrun} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got rdy=%b act=%b code=%0h ov=%b ob=%b busy=%b done=%b err=%b exp all 0",
                 c, in_ready, dec_active, dec_code, out_valid, out_bit, busy, done, err_underrun);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({in_ready, dec_active, dec_code, out_valid, out_bit, busy, done, err_underrun} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got rdy=%b act=%b code=%0h ov=%b busy=%b done=%b err=%b exp all 0",
                 c, in_ready, dec_active, dec_code, out_valid, busy, done, err_underrun);
      end
    end
    last_bit = 1'b0;
  endtask

  // umode: 0 all valid, 1 symbol 2 missing, 2 random gaps.
  task automatic test_frame(input int n, input int umode, input bit noise);
    logic [WD_CODE-1:0] codes [$];
    bit                 vld [$];
    int                 first_bad;
    int                 done_t;
    logic [WD_CODE-1:0] pres;
    logic [WD_CODE-1:0] e_code;
    logic               e_ov;
    logic               e_bit;
    codes.delete(); vld.delete();
    first_bad = -1;
    for (int k = 0; k < n; k++) begin
      codes.push_back(WD_CODE'($urandom));
      if (umode == 0)      vld.push_back(1'b1);
      else if (umode == 1) vld.push_back(k != 2);
      else                 vld.push_back($urandom_range(3) != 0);
      if (!vld[k] && first_bad < 0) first_bad = k;
    end
    done_t = n + TAIL_EFF + LAT + 1;
    @(posedge clk); #1;
    start = 1'b1; frame_len = FW'(n); in_valid = 1'b0;
    for (int t = 0; t <= done_t + 2; t++) begin
      @(posedge clk); #1;
      start     = noise && (t < n) && ($urandom_range(2) == 0);
      frame_len = FW'($urandom);
      if (t < n) begin
        in_valid = vld[t]; in_code = codes[t];
      end else begin
        in_valid = 1'($urandom); in_code = WD_CODE'($urandom);
      end
      e_code = '0;
      if (t >= 1 && t <= n) e_code = vld[t-1] ? codes[t-1] : '0;
      e_ov = (t >= LAT + 2) && (t <= n + LAT + 1);
      if (e_ov) begin
        pres = vld[t-LAT-2] ? codes[t-LAT-2] : '0;
        last_bit = ^pres;
      end
      e_bit = last_bit;
      n_tests += 8;
      if (in_ready !== (t < n)) begin
        n_fail++; $display("FAIL in_ready n=%0d t=%0d got %b exp %b", n, t, in_ready, (t < n));
      end
      if (busy !== (t <= done_t)) begin
        n_fail++; $display("FAIL busy n=%0d t=%0d got %b exp %b", n, t, busy, (t <= done_t));
      end
      if (done !== (t == done_t)) begin
        n_fail++; $display("FAIL done n=%0d t=%0d got %b exp %b", n, t, done, (t == done_t));
      end
      if (dec_active !== (t >= 1 && t < done_t)) begin
        n_fail++; $display("FAIL dec_active n=%0d t=%0d got %b exp %b", n, t, dec_active, (t >= 1 && t < done_t));
      end
      if (dec_code !== e_code) begin
        n_fail++; $display("FAIL dec_code n=%0d t=%0d got %0h exp %0h", n, t, dec_code, e_code);
      end
      if (out_valid !== e_ov) begin
        n_fail++; $display("FAIL out_valid n=%0d t=%0d got %b exp %b", n, t, out_valid, e_ov);
      end
      if (out_bit !== e_bit) begin
        n_fail++; $display("FAIL out_bit n=%0d t=%0d got %b exp %b", n, t, out_bit, e_bit);
      end
      if (err_underrun !== (first_bad >= 0 && t >= first_bad + 1)) begin
        n_fail++; $display("FAIL err_underrun n=%0d t=%0d got %b exp %b", n, t, err_underrun,
                           (first_bad >= 0 && t >= first_bad + 1));
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1;
    start = 1'b1; frame_len = '0; in_valid = 1'b1; in_code = '1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_tests += 4;
      if (done !== (t == 0)) begin
        n_fail++; $display("FAIL zero_done t=%0d got %b exp %b", t, done, (t == 0));
      end
      if (busy !== (t == 0)) begin
        n_fail++; $display("FAIL zero_busy t=%0d got %b exp %b", t, busy, (t == 0));
      end
      if ({dec_active, in_ready, out_valid} !== 3'b000) begin
        n_fail++; $display("FAIL zero_quiet t=%0d got act=%b rdy=%b ov=%b exp 0", t, dec_active, in_ready, out_valid);
      end
      if (err_underrun !== 1'b0) begin
        n_fail++; $display("FAIL zero_err_clear t=%0d got %b exp 0", t, err_underrun);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_drain();
    @(posedge clk); #1;
    start = 1'b1; frame_len = FW'(6); in_valid = 1'b1; in_code = WD_CODE'($urandom);
    for (int t = 0; t < 6 + TAIL_EFF + 10; t++) begin
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_code = WD_CODE'($urandom);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_busy got %b exp 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, dec_active, dec_code, out_valid, out_bit, busy, done, err_underrun} !== '0) begin
      n_fail++;
      $display("FAIL drain_reset_now got rdy=%b act=%b code=%0h ov=%b ob=%b busy=%b done=%b exp all 0",
               in_ready, dec_active, dec_code, out_valid, out_bit, busy, done);
    end
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    last_bit = 1'b0;
    for (int c = 0; c < LAT + 10; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, done, busy, dec_active} !== 4'b0000) begin
        n_fail++; $display("FAIL drain_after c=%0d got ov=%b done=%b busy=%b act=%b exp 0", c, out_valid, done, busy, dec_active);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; last_bit = 1'b0;
    rst_n = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_code = '0;
    test_reset();
    test_frame(16, 0, 1'b0);
    test_frame(4, 1, 1'b0);
    test_zero_len();
    test_frame(1, 0, 1'b1);
    for (int i = 0; i < 3; i++) test_frame(int'($urandom_range(40, 2)), 2, 1'b1);
    test_reset_drain();
    test_frame(16, 2, 1'b1);
    test_frame((1 << FW) - 1, 2, 1'b0);
    test_frame(3, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
